// File: rtl/msrv_alu_mdu_if.sv
// Issue/result handshake bundle for the msrv execute unit.
// The master side issues operations and consumes results; the slave is the ALU/MDU.
interface msrv_alu_mdu_if #(
    parameter int XLEN = 32
);
    logic            valid_in;
    logic            ready_out;
    logic            m_op_in;
    logic [3:0]      opcode_in;
    logic [XLEN-1:0] op_1_in;
    logic [XLEN-1:0] op_2_in;
    logic            flush_in;
    logic            result_valid_out;
    logic            ready_in;
    logic [XLEN-1:0] result_out;
    logic            illegal_out;

    modport master (
        output valid_in, m_op_in, opcode_in, op_1_in, op_2_in, flush_in, ready_in,
        input  ready_out, result_valid_out, result_out, illegal_out
    );

    modport slave (
        input  valid_in, m_op_in, opcode_in, op_1_in, op_2_in, flush_in, ready_in,
        output ready_out, result_valid_out, result_out, illegal_out
    );
endinterface

// File: rtl/msrv_alu_mdu.sv
// msrv execute unit: single-cycle RV base ALU plus an iterative radix-2 M-extension
// multiply/divide datapath sharing one issue port and one result port.
// Build option: define MSRV_ALU_MDU_EN to build the multiply/divide datapath;
// without it M ops complete in one cycle with result 0 and illegal_out set.
module msrv_alu_mdu #(
    parameter int XLEN = 32
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    msrv_alu_mdu_if.slave bus
);
    localparam int SHW = $clog2(XLEN);

`ifdef MSRV_ALU_MDU_EN
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_DONE} state_t;
`endif

    state_t          state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            illegal_q, illegal_d;
    logic            ready;
    logic            accept;
    logic            handoff;

    // Two's-complement negate when neg is set; used for magnitudes and sign fix-up.
    function automatic logic [XLEN-1:0] apply_sign(input logic neg, input logic [XLEN-1:0] v);
        apply_sign = neg ? -v : v;
    endfunction

    function automatic logic [2*XLEN-1:0] apply_sign_wide(input logic neg,
                                                          input logic [2*XLEN-1:0] v);
        apply_sign_wide = neg ? -v : v;
    endfunction

    // Base integer ALU; opc[3] selects SUB / SRA.
    function automatic logic [XLEN-1:0] alu_base(input logic [3:0]      opc,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
        logic signed [XLEN-1:0] a_s;
        logic signed [XLEN-1:0] b_s;
        logic signed [XLEN-1:0] sra;
        logic [SHW-1:0]         sh;
        a_s = a;
        b_s = b;
        sh  = b[SHW-1:0];
        sra = a_s >>> sh;   // kept separate so the arithmetic shift stays signed
        case (opc[2:0])
            3'b000:  alu_base = opc[3] ? (a - b) : (a + b);
            3'b001:  alu_base = a << sh;
            3'b010:  alu_base = {{(XLEN-1){1'b0}}, (a_s < b_s)};
            3'b011:  alu_base = {{(XLEN-1){1'b0}}, (a < b)};
            3'b100:  alu_base = a ^ b;
            3'b101:  alu_base = opc[3] ? sra : (a >> sh);
            3'b110:  alu_base = a | b;
            default: alu_base = a & b;
        endcase
    endfunction

    assign ready   = ((state_q == S_IDLE) | ((state_q == S_DONE) & bus.ready_in)) & ~bus.flush_in;
    assign accept  = bus.valid_in & ready;
    assign handoff = (state_q == S_DONE) & bus.ready_in;

    assign bus.ready_out        = ready;
    assign bus.result_valid_out = (state_q == S_DONE);
    assign bus.result_out       = result_q;
    assign bus.illegal_out      = illegal_q;

`ifdef MSRV_ALU_MDU_EN
    // acc: running partial product high half / partial remainder.
    // mq:  multiplier shifting out / quotient shifting in.
    // dvs: multiplicand or divisor magnitude.
    logic [XLEN-1:0]   acc_q, acc_d, mq_q, mq_d, dvs_q, dvs_d;
    logic [SHW-1:0]    cnt_q, cnt_d;
    logic [2:0]        fn_q, fn_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   acc_step, mq_step, step_result;
    logic [XLEN:0]     sum, shifted, diff;
    logic [2*XLEN-1:0] prod;
    logic [2:0]        funct;
    logic              a_sgn, b_sgn, div0, ovf;
    logic [XLEN-1:0]   a_mag, b_mag;

    // Decode the issuing M op: operand signedness, magnitudes and fast-path divides.
    always_comb begin
        funct = bus.opcode_in[2:0];
        a_sgn = bus.op_1_in[XLEN-1] &
                ((funct == 3'b001) | (funct == 3'b010) | (funct == 3'b100) | (funct == 3'b110));
        b_sgn = bus.op_2_in[XLEN-1] &
                ((funct == 3'b001) | (funct == 3'b100) | (funct == 3'b110));
        a_mag = apply_sign(a_sgn, bus.op_1_in);
        b_mag = apply_sign(b_sgn, bus.op_2_in);
        div0  = funct[2] & (bus.op_2_in == '0);
        ovf   = funct[2] & ~funct[0] &
                (bus.op_1_in == {1'b1, {(XLEN-1){1'b0}}}) & (&bus.op_2_in);
    end

    // One shift-add or restoring shift-subtract step, plus the fixed-up final result.
    always_comb begin
        sum     = {1'b0, acc_q} + (mq_q[0] ? {1'b0, dvs_q} : '0);
        shifted = {acc_q, mq_q[XLEN-1]};
        diff    = shifted - {1'b0, dvs_q};
        if (!fn_q[2]) begin
            acc_step = sum[XLEN:1];
            mq_step  = {sum[0], mq_q[XLEN-1:1]};
        end else if (!diff[XLEN]) begin
            acc_step = diff[XLEN-1:0];
            mq_step  = {mq_q[XLEN-2:0], 1'b1};
        end else begin
            acc_step = shifted[XLEN-1:0];
            mq_step  = {mq_q[XLEN-2:0], 1'b0};
        end
        prod = apply_sign_wide(neg_q, {acc_step, mq_step});
        if (!fn_q[2]) begin
            step_result = (fn_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end else begin
            step_result = fn_q[1] ? apply_sign(neg_q, acc_step) : apply_sign(neg_q, mq_step);
        end
    end
`endif

    // Next-state, result and datapath register updates.
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        illegal_d = illegal_q;
`ifdef MSRV_ALU_MDU_EN
        acc_d = acc_q;
        mq_d  = mq_q;
        dvs_d = dvs_q;
        cnt_d = cnt_q;
        fn_d  = fn_q;
        neg_d = neg_q;
`endif
        if (bus.flush_in) begin
            state_d = S_IDLE;
        end else begin
            if (handoff) begin
                state_d = S_IDLE;
            end
`ifdef MSRV_ALU_MDU_EN
            if (state_q == S_BUSY) begin
                acc_d = acc_step;
                mq_d  = mq_step;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    result_d  = step_result;
                    illegal_d = 1'b0;
                    state_d   = S_DONE;
                end
            end
`endif
            if (accept) begin
                illegal_d = 1'b0;
                state_d   = S_DONE;
                if (!bus.m_op_in) begin
                    result_d = alu_base(bus.opcode_in, bus.op_1_in, bus.op_2_in);
                end else begin
`ifdef MSRV_ALU_MDU_EN
                    if (div0) begin
                        result_d = funct[1] ? bus.op_1_in : '1;
                    end else if (ovf) begin
                        result_d = funct[1] ? '0 : bus.op_1_in;
                    end else begin
                        state_d = S_BUSY;
                        acc_d   = '0;
                        mq_d    = funct[2] ? a_mag : b_mag;
                        dvs_d   = funct[2] ? b_mag : a_mag;
                        cnt_d   = SHW'(XLEN - 1);
                        fn_d    = funct;
                        neg_d   = (funct[2] & funct[1]) ? a_sgn : (a_sgn ^ b_sgn);
                    end
`else
                    result_d  = '0;
                    illegal_d = 1'b1;
`endif
                end
            end
        end
    end

    // State and datapath registers; reset returns to IDLE with cleared outputs.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= S_IDLE;
            result_q  <= '0;
            illegal_q <= 1'b0;
`ifdef MSRV_ALU_MDU_EN
            acc_q <= '0;
            mq_q  <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
            fn_q  <= '0;
            neg_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
`ifdef MSRV_ALU_MDU_EN
            acc_q <= acc_d;
            mq_q  <= mq_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
            fn_q  <= fn_d;
            neg_q <= neg_d;
`endif
        end
    end
endmodule
